// File: rtl/keyed_sec_pipe.sv
// keyed_sec_pipe
// Two-stage pipelined Hamming single-error-correcting decoder with a serially
// loaded locking key. A wrong key XOR-corrupts the decoder input (low key half)
// and the decoder output (high key half); the correct key makes both masks zero.
//
// Build option: define SECDED_EN to add an overall-parity bit as in_chk MSB and
// switch the classification to SECDED rules.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   key_shift, key_bit       serial key load, LSB first
//   key_loaded               KEY_W shifts seen since reset
//   corr_en                  1 = flip the located data bit, 0 = report only
//   in_valid/in_ready        input handshake; in_data, in_chk received word
//   out_valid/out_ready      output handshake
//   out_data, out_synd       corrected (then output-masked) data, syndrome
//   out_err                  00 none, 01 single/check-bit error, 10 uncorrectable
module keyed_sec_pipe #(
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       CHK_W       = 8,
    parameter int unsigned       KEY_W       = 16,
    parameter logic [KEY_W-1:0]  KEY_CORRECT = 16'hA5C3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              key_shift,
    input  logic              key_bit,
    output logic              key_loaded,
    input  logic              corr_en,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef SECDED_EN
    input  logic [CHK_W:0]    in_chk,
`else
    input  logic [CHK_W-1:0]  in_chk,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_synd,
    output logic [1:0]        out_err
);

    localparam int unsigned HALF  = KEY_W / 2;
    localparam int unsigned CNT_W = $clog2(KEY_W + 1);

    typedef enum logic [1:0] {
        ERR_NONE   = 2'b00,
        ERR_SINGLE = 2'b01,
        ERR_UNCORR = 2'b10
    } err_e;

    // Code position of data bit idx: the idx-th position >= 3 that is not a
    // power of two. Constant-folded wherever it is called with a loop index.
    function automatic logic [CHK_W-1:0] data_pos(int unsigned idx);
        logic [CHK_W-1:0] pos;
        int unsigned      seen;
        pos  = '0;
        seen = 0;
        for (int unsigned p = 3; p <= DATA_W + CHK_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (seen == idx) pos = CHK_W'(p);
                seen++;
            end
        end
        return pos;
    endfunction

    logic [KEY_W-1:0]  key_q;
    logic [CNT_W-1:0]  key_cnt_q;

    logic              s1_valid_q;
    logic [DATA_W-1:0] s1_data_q,  s1_data_d;
    logic [CHK_W-1:0]  s1_synd_q,  s1_synd_d;
    logic              s1_corr_q;
    logic [HALF-1:0]   s1_omask_q;
`ifdef SECDED_EN
    logic              s1_perr_q,  s1_perr_d;
`endif

    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [CHK_W-1:0]  out_synd_q;
    err_e              out_err_q,  out_err_d;

    logic [KEY_W-1:0]  mask;
    logic [HALF-1:0]   in_mask, out_mask;
    logic [CHK_W-1:0]  calc;
    logic              in_fire, s2_adv;

    assign in_ready   = !out_valid_q || out_ready || !s1_valid_q;
    assign in_fire    = in_valid && in_ready;
    assign s2_adv     = s1_valid_q && (!out_valid_q || out_ready);
    assign key_loaded = (key_cnt_q == CNT_W'(KEY_W));

    assign out_valid  = out_valid_q;
    assign out_data   = out_data_q;
    assign out_synd   = out_synd_q;
    assign out_err    = out_err_q;

    // Stage 1: input masking and syndrome. XOR-ing the positions of all set
    // data bits yields every check bit at once.
    always_comb begin
        mask      = key_q ^ KEY_CORRECT;
        in_mask   = mask[HALF-1:0];
        out_mask  = mask[KEY_W-1:HALF];
        s1_data_d = in_data ^ DATA_W'(in_mask);
        calc      = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (s1_data_d[i]) calc = calc ^ data_pos(i);
        end
        s1_synd_d = calc ^ in_chk[CHK_W-1:0];
`ifdef SECDED_EN
        // Stored parity covers data and check bits, so a clean word XORs to 0.
        s1_perr_d = ^{s1_data_d, in_chk};
`endif
    end

    // Stage 2: classify syndrome and apply correction.
    logic              hit, pow2;
    logic [DATA_W-1:0] flip, corr;

    always_comb begin
        hit  = 1'b0;
        flip = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (s1_synd_q == data_pos(i)) begin
                hit     = 1'b1;
                flip[i] = 1'b1;
            end
        end
        pow2      = (s1_synd_q != '0) && ((s1_synd_q & (s1_synd_q - 1'b1)) == '0);
        corr      = s1_data_q;
        out_err_d = ERR_NONE;
`ifdef SECDED_EN
        if (s1_synd_q == '0) begin
            out_err_d = s1_perr_q ? ERR_SINGLE : ERR_NONE;
        end else if (!s1_perr_q) begin
            out_err_d = ERR_UNCORR;
        end else if (pow2) begin
            out_err_d = ERR_SINGLE;
        end else if (hit) begin
            out_err_d = ERR_SINGLE;
            if (s1_corr_q) corr = s1_data_q ^ flip;
        end else begin
            out_err_d = ERR_UNCORR;
        end
`else
        if (s1_synd_q == '0) begin
            out_err_d = ERR_NONE;
        end else if (pow2) begin
            out_err_d = ERR_SINGLE;
        end else if (hit) begin
            out_err_d = ERR_SINGLE;
            if (s1_corr_q) corr = s1_data_q ^ flip;
        end else begin
            out_err_d = ERR_UNCORR;
        end
`endif
        out_data_d = corr ^ DATA_W'(s1_omask_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q       <= '0;
            key_cnt_q   <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s1_synd_q   <= '0;
            s1_corr_q   <= 1'b0;
            s1_omask_q  <= '0;
`ifdef SECDED_EN
            s1_perr_q   <= 1'b0;
`endif
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_synd_q  <= '0;
            out_err_q   <= ERR_NONE;
        end else begin
            if (key_shift) begin
                key_q <= {key_bit, key_q[KEY_W-1:1]};
                if (!key_loaded) key_cnt_q <= key_cnt_q + 1'b1;
            end

            // Masks are captured with the word, so later key shifts cannot
            // touch words already in flight.
            if (in_fire) begin
                s1_valid_q <= 1'b1;
                s1_data_q  <= s1_data_d;
                s1_synd_q  <= s1_synd_d;
                s1_corr_q  <= corr_en;
                s1_omask_q <= out_mask;
`ifdef SECDED_EN
                s1_perr_q  <= s1_perr_d;
`endif
            end else if (s2_adv) begin
                s1_valid_q <= 1'b0;
            end

            if (s2_adv) begin
                out_valid_q <= 1'b1;
                out_data_q  <= out_data_d;
                out_synd_q  <= s1_synd_q;
                out_err_q   <= out_err_d;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

endmodule
